// File: rtl/keypad_pkg.sv
// Shared state encoding and digit constants for the keypad entry path.
package keypad_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

endpackage

// File: rtl/keypad_debounce.sv
// Synchronises the encoder D/V pair and debounces presses and releases,
// producing one strobe per accepted key press.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DIGIT_W-1:0] d,
  input  logic               v,
  output logic               key_strobe,
  output logic [DIGIT_W-1:0] key_value
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [DIGIT_W-1:0] d_meta_q, d_sync_q;
  logic               v_meta_q, v_sync_q;
  kp_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [DIGIT_W-1:0] cand_q, cand_d;
  logic               strobe_q, strobe_d;
  logic [DIGIT_W-1:0] value_q, value_d;
  logic               present;

  // V idles high, so its synchroniser resets to "no key".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_meta_q <= '0;
      d_sync_q <= '0;
      v_meta_q <= 1'b1;
      v_sync_q <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      strobe_q <= 1'b0;
      value_q  <= '0;
    end else begin
      d_meta_q <= d;
      d_sync_q <= d_meta_q;
      v_meta_q <= v;
      v_sync_q <= v_meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      strobe_q <= strobe_d;
      value_q  <= value_d;
    end
  end

  assign present = !v_sync_q && (d_sync_q <= MAX_DIGIT);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    strobe_d = 1'b0;
    value_d  = value_q;
    case (state_q)
      IDLE: begin
        if (present) begin
          cand_d = d_sync_q;
          cnt_d  = ONE;
          if (ONE == CNT_MAX) begin
            state_d  = HELD;
            strobe_d = 1'b1;
            value_d  = d_sync_q;
          end else begin
            state_d = PRESS_DB;
          end
        end
      end
      PRESS_DB: begin
        if (!present) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (d_sync_q != cand_q) begin
          cand_d = d_sync_q;
          cnt_d  = ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d  = HELD;
            strobe_d = 1'b1;
            value_d  = cand_q;
          end
        end
      end
      HELD: begin
        if (!present) begin
          cnt_d   = ONE;
          state_d = (ONE == CNT_MAX) ? IDLE : REL_DB;
        end
      end
      REL_DB: begin
        if (present) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_strobe = strobe_q;
  assign key_value  = value_q;

endmodule

// File: rtl/keypad_digit_register.sv
// Debounced keypad entry buffer: shifts accepted digits into a BCD buffer
// and publishes it as a code word on enter.
module keypad_digit_register
  import keypad_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [3:0]                   D,
  input  logic                         V,
  input  logic                         clear,
  input  logic                         enter,
  output logic                         key_strobe,
  output logic [3:0]                   key_value,
  output logic [4*DIGITS-1:0]          digits,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full,
  output logic                         overflow,
  output logic [4*DIGITS-1:0]          code,
  output logic                         code_valid
);

  localparam int BUF_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic [BUF_W-1:0] digits_q, digits_d, shifted;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BUF_W-1:0] code_q, code_d;
  logic             code_valid_q, code_valid_d;
  logic             overflow_q, overflow_d;
  logic             full_w;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .resetn    (resetn),
    .d         (D),
    .v         (V),
    .key_strobe(key_strobe),
    .key_value (key_value)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits_q     <= '0;
      count_q      <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      count_q      <= count_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign full_w  = (count_q == CNT_W'(DIGITS));
  assign shifted = (digits_q << DIGIT_W) | BUF_W'(key_value);

  // clear beats enter, enter beats a fresh digit; enter still keeps a
  // same-cycle digit as the first entry of the new buffer.
  always_comb begin
    digits_d     = digits_q;
    count_d      = count_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    overflow_d   = 1'b0;
    if (clear) begin
      digits_d = '0;
      count_d  = '0;
    end else if (enter) begin
      code_d       = digits_q;
      code_valid_d = 1'b1;
      if (key_strobe) begin
        digits_d = BUF_W'(key_value);
        count_d  = CNT_W'(1);
      end else begin
        digits_d = '0;
        count_d  = '0;
      end
    end else if (key_strobe) begin
      if (full_w) begin
        overflow_d = 1'b1;
      end else begin
        digits_d = shifted;
        count_d  = count_q + CNT_W'(1);
      end
    end
  end

  assign digits     = digits_q;
  assign count      = count_q;
  assign full       = full_w;
  assign overflow   = overflow_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;

endmodule
